// File: rtl/shim_shutdown_sense_monitor_if.sv
// Bundle of the monitor's control, sense and status signals.
//   master: system side; drives sys_en, fault_clear and shutdown_sense, observes status.
//   slave:  the monitor; observes the inputs, drives the scanner enable and all status outputs.
interface shim_shutdown_sense_monitor_if #(
    parameter int unsigned TS_WIDTH = 32
) ();
    logic                sys_en;
    logic                fault_clear;
    logic [7:0]          shutdown_sense;
    logic                shutdown_sense_en;
    logic                shutdown_req;
    logic                fault_irq;
    logic [2:0]          fault_first_ch;
    logic                fault_first_valid;
    logic [7:0]          fault_mask;
    logic [3:0]          fault_count;
    logic [TS_WIDTH-1:0] fault_timestamp;
    logic [1:0]          monitor_state;

    modport master (
        output sys_en, fault_clear, shutdown_sense,
        input  shutdown_sense_en, shutdown_req, fault_irq, fault_first_ch, fault_first_valid,
               fault_mask, fault_count, fault_timestamp, monitor_state
    );

    modport slave (
        input  sys_en, fault_clear, shutdown_sense,
        output shutdown_sense_en, shutdown_req, fault_irq, fault_first_ch, fault_first_valid,
               fault_mask, fault_count, fault_timestamp, monitor_state
    );
endinterface

// File: rtl/shim_shutdown_sense_monitor.sv
// Shutdown-sense monitor. Owns the sense scanner's enable, watches its sticky 8-bit sense
// vector and turns the first asserted channel into a shutdown request, first-fault record,
// timestamp and a one-cycle interrupt.
//
// Ports:
//   clk  - system clock, all logic on posedge
//   rst  - synchronous active-high reset
//   bus  - slave modport of shim_shutdown_sense_monitor_if:
//          in : sys_en, fault_clear, shutdown_sense
//          out: shutdown_sense_en, shutdown_req, fault_irq, fault_first_ch, fault_first_valid,
//               fault_mask, fault_count, fault_timestamp, monitor_state
// All outputs are registered.
module shim_shutdown_sense_monitor #(
    parameter int unsigned ARM_DELAY = 16,
    parameter int unsigned TS_WIDTH  = 32
) (
    input logic                          clk,
    input logic                          rst,
    shim_shutdown_sense_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArming  = 2'd1,
        StMonitor = 2'd2,
        StTripped = 2'd3
    } state_e;

    localparam logic [15:0] ArmLast = 16'(ARM_DELAY - 1);

    state_e              state_q, state_d;
    logic [15:0]         arm_cnt_q, arm_cnt_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                sense_en_q, sense_en_d;
    logic                req_q, req_d;
    logic                irq_q, irq_d;
    logic [2:0]          first_ch_q, first_ch_d;
    logic                first_valid_q, first_valid_d;
    logic [7:0]          mask_q, mask_d;
    logic [3:0]          count_q, count_d;
    logic [TS_WIDTH-1:0] timestamp_q, timestamp_d;

    logic trip;
    logic running;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] ch;
        ch = 3'd0;
        // Walk downwards so the lowest set index is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                ch = 3'(i);
            end
        end
        return ch;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    assign trip    = |bus.shutdown_sense;
    assign running = (state_q == StArming) || (state_q == StMonitor);

    always_comb begin
        state_d       = state_q;
        arm_cnt_d     = arm_cnt_q;
        ts_d          = ts_q;
        first_ch_d    = first_ch_q;
        first_valid_d = first_valid_q;
        mask_d        = mask_q;
        count_d       = count_q;
        timestamp_d   = timestamp_q;

        // Timestamp counter saturates rather than wrapping so a long run never looks early.
        if (running && (ts_q != {TS_WIDTH{1'b1}})) begin
            ts_d = ts_q + TS_WIDTH'(1);
        end

        case (state_q)
            StIdle: begin
                if (bus.sys_en) begin
                    state_d       = StArming;
                    arm_cnt_d     = 16'd0;
                    ts_d          = '0;
                    mask_d        = 8'd0;
                    count_d       = 4'd0;
                    first_valid_d = 1'b0;
                    first_ch_d    = 3'd0;
                    timestamp_d   = '0;
                end
            end
            StArming: begin
                // Faults seen while the scanner settles are still real faults.
                if (trip) begin
                    state_d = StTripped;
                end else if (!bus.sys_en) begin
                    state_d = StIdle;
                end else if (arm_cnt_q == ArmLast) begin
                    state_d = StMonitor;
                end else begin
                    arm_cnt_d = arm_cnt_q + 16'd1;
                end
            end
            StMonitor: begin
                if (trip) begin
                    state_d = StTripped;
                end else if (!bus.sys_en) begin
                    state_d = StIdle;
                end
            end
            StTripped: begin
                // Count lags the mask by one cycle and is frozen once we leave TRIPPED.
                count_d = popcount8(mask_q);
                if (bus.fault_clear) begin
                    state_d = StIdle;
                    mask_d  = 8'd0;
                end else begin
                    mask_d = mask_q | bus.shutdown_sense;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // First-fault capture on the trip edge.
        if (running && trip) begin
            first_ch_d    = lowest_set(bus.shutdown_sense);
            first_valid_d = 1'b1;
            timestamp_d   = ts_q;
            mask_d        = bus.shutdown_sense;
        end

        sense_en_d = (state_d != StIdle);
        req_d      = (state_d == StTripped);
        irq_d      = (state_d == StTripped) && (state_q != StTripped);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            arm_cnt_q     <= 16'd0;
            ts_q          <= '0;
            sense_en_q    <= 1'b0;
            req_q         <= 1'b0;
            irq_q         <= 1'b0;
            first_ch_q    <= 3'd0;
            first_valid_q <= 1'b0;
            mask_q        <= 8'd0;
            count_q       <= 4'd0;
            timestamp_q   <= '0;
        end else begin
            state_q       <= state_d;
            arm_cnt_q     <= arm_cnt_d;
            ts_q          <= ts_d;
            sense_en_q    <= sense_en_d;
            req_q         <= req_d;
            irq_q         <= irq_d;
            first_ch_q    <= first_ch_d;
            first_valid_q <= first_valid_d;
            mask_q        <= mask_d;
            count_q       <= count_d;
            timestamp_q   <= timestamp_d;
        end
    end

    assign bus.shutdown_sense_en = sense_en_q;
    assign bus.shutdown_req      = req_q;
    assign bus.fault_irq         = irq_q;
    assign bus.fault_first_ch    = first_ch_q;
    assign bus.fault_first_valid = first_valid_q;
    assign bus.fault_mask        = mask_q;
    assign bus.fault_count       = count_q;
    assign bus.fault_timestamp   = timestamp_q;
    assign bus.monitor_state     = state_q;

endmodule

// File: tb/tb_shim_shutdown_sense_monitor.sv
// Directed bench for shim_shutdown_sense_monitor with hand-computed expectations.
module tb_shim_shutdown_sense_monitor;

    localparam int unsigned TS_W = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    shim_shutdown_sense_monitor_if #(.TS_WIDTH(TS_W)) bus ();

    shim_shutdown_sense_monitor #(
        .ARM_DELAY(16),
        .TS_WIDTH (TS_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [1:0] st, input logic en,
                             input logic req, input logic irq);
        check({tag, ".state"}, 64'(bus.monitor_state), 64'(st));
        check({tag, ".sense_en"}, 64'(bus.shutdown_sense_en), 64'(en));
        check({tag, ".req"}, 64'(bus.shutdown_req), 64'(req));
        check({tag, ".irq"}, 64'(bus.fault_irq), 64'(irq));
    endtask

    task automatic arm_to_monitor(input string tag);
        bus.sys_en = 1'b1;
        bus.fault_clear = 1'b0;
        bus.shutdown_sense = 8'h00;
        tick();
        check_ctl({tag, ".arming"}, 2'd1, 1'b1, 1'b0, 1'b0);
        repeat (16) tick();
        check_ctl({tag, ".monitor"}, 2'd2, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.sys_en = 1'b0;
        bus.fault_clear = 1'b0;
        bus.shutdown_sense = 8'h00;
        tick();
        tick();

        // Reset values
        check_ctl("reset", 2'd0, 1'b0, 1'b0, 1'b0);
        check("reset.mask", 64'(bus.fault_mask), 64'h0);
        check("reset.count", 64'(bus.fault_count), 64'h0);
        check("reset.first_valid", 64'(bus.fault_first_valid), 64'h0);
        check("reset.first_ch", 64'(bus.fault_first_ch), 64'h0);
        check("reset.ts", 64'(bus.fault_timestamp), 64'h0);

        // Arm: sense_en from first cycle, ARMING lasts 16 cycles
        rst = 1'b0;
        bus.sys_en = 1'b1;
        tick();
        check_ctl("arm1", 2'd1, 1'b1, 1'b0, 1'b0);
        repeat (15) tick();
        check_ctl("arm16", 2'd1, 1'b1, 1'b0, 1'b0);
        tick();
        check_ctl("mon0", 2'd2, 1'b1, 1'b0, 1'b0);
        check("mon0.first_valid", 64'(bus.fault_first_valid), 64'h0);

        // 100 cycles into MONITOR the timestamp counter reads 116
        repeat (100) tick();
        bus.shutdown_sense = 8'b0010_0100;
        tick();
        check_ctl("trip", 2'd3, 1'b1, 1'b1, 1'b1);
        check("trip.first_ch", 64'(bus.fault_first_ch), 64'd2);
        check("trip.first_valid", 64'(bus.fault_first_valid), 64'd1);
        check("trip.mask", 64'(bus.fault_mask), 64'h24);
        check("trip.count_lag", 64'(bus.fault_count), 64'd0);
        check("trip.ts", 64'(bus.fault_timestamp), 64'd116);

        // Sticky TRIPPED: sys_en ignored, mask accumulates, count lags
        bus.shutdown_sense = 8'hA4;
        bus.sys_en = 1'b0;
        tick();
        check_ctl("trip2", 2'd3, 1'b1, 1'b1, 1'b0);
        check("trip2.mask", 64'(bus.fault_mask), 64'hA4);
        check("trip2.count", 64'(bus.fault_count), 64'd2);
        tick();
        check("trip3.count", 64'(bus.fault_count), 64'd3);
        check("trip3.state", 64'(bus.monitor_state), 64'd3);

        // Clear: back to IDLE, record held
        bus.fault_clear = 1'b1;
        tick();
        check_ctl("clear", 2'd0, 1'b0, 1'b0, 1'b0);
        check("clear.mask", 64'(bus.fault_mask), 64'h0);
        check("clear.first_ch", 64'(bus.fault_first_ch), 64'd2);
        check("clear.first_valid", 64'(bus.fault_first_valid), 64'd1);
        check("clear.ts", 64'(bus.fault_timestamp), 64'd116);
        check("clear.count", 64'(bus.fault_count), 64'd3);
        bus.fault_clear = 1'b0;
        bus.shutdown_sense = 8'h00;
        tick();
        check("idle_hold.count", 64'(bus.fault_count), 64'd3);

        // Trip during ARMING at arm cycle 3
        bus.sys_en = 1'b1;
        tick();
        check("rearm.count", 64'(bus.fault_count), 64'd0);
        check("rearm.first_valid", 64'(bus.fault_first_valid), 64'd0);
        check("rearm.ts", 64'(bus.fault_timestamp), 64'd0);
        repeat (3) tick();
        bus.shutdown_sense = 8'h01;
        tick();
        check_ctl("armtrip", 2'd3, 1'b1, 1'b1, 1'b1);
        check("armtrip.first_ch", 64'(bus.fault_first_ch), 64'd0);
        check("armtrip.ts", 64'(bus.fault_timestamp), 64'd3);
        bus.sys_en = 1'b0;
        bus.shutdown_sense = 8'h00;
        bus.fault_clear = 1'b1;
        tick();
        check_ctl("armtrip.clear", 2'd0, 1'b0, 1'b0, 1'b0);
        bus.fault_clear = 1'b0;

        // sys_en dropped during ARMING
        bus.sys_en = 1'b1;
        tick();
        bus.sys_en = 1'b0;
        tick();
        check_ctl("arm_drop", 2'd0, 1'b0, 1'b0, 1'b0);

        // sys_en dropped in MONITOR with no fault
        arm_to_monitor("m1");
        bus.sys_en = 1'b0;
        tick();
        check_ctl("mon_drop", 2'd0, 1'b0, 1'b0, 1'b0);

        // sys_en drop and sense bit together: trip wins
        arm_to_monitor("m2");
        bus.sys_en = 1'b0;
        bus.shutdown_sense = 8'h10;
        tick();
        check_ctl("drop_trip", 2'd3, 1'b1, 1'b1, 1'b1);
        check("drop_trip.first_ch", 64'(bus.fault_first_ch), 64'd4);
        check("drop_trip.ts", 64'(bus.fault_timestamp), 64'd16);

        // Clear wins over a new sense bit
        bus.fault_clear = 1'b1;
        bus.shutdown_sense = 8'h50;
        tick();
        check_ctl("clear_win", 2'd0, 1'b0, 1'b0, 1'b0);
        check("clear_win.mask", 64'(bus.fault_mask), 64'h0);
        check("clear_win.count", 64'(bus.fault_count), 64'd1);
        bus.fault_clear = 1'b0;
        bus.shutdown_sense = 8'h00;

        // Reset while TRIPPED
        arm_to_monitor("m3");
        bus.shutdown_sense = 8'h80;
        tick();
        check("rtrip.first_ch", 64'(bus.fault_first_ch), 64'd7);
        rst = 1'b1;
        tick();
        check_ctl("rst_trip", 2'd0, 1'b0, 1'b0, 1'b0);
        check("rst_trip.mask", 64'(bus.fault_mask), 64'h0);
        check("rst_trip.first_valid", 64'(bus.fault_first_valid), 64'h0);
        check("rst_trip.first_ch", 64'(bus.fault_first_ch), 64'h0);
        check("rst_trip.ts", 64'(bus.fault_timestamp), 64'h0);
        check("rst_trip.count", 64'(bus.fault_count), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
